instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction-fetch initiator driving the word-addressed synchronous-read ROM port (addr -> q, 1-cycle latency).
//   Owns the fetch PC and issues one word address per cycle.
//   Buffers returned words in a 2-entry skid FIFO.
//   Presents {pc, instr} to decode over a valid/ready handshake; supports branch/jump redirect with flush.
// PARAMETERS
//   DEPTH          16384            ROM depth; sizes the address space
//   ADDRESS_WIDTH  $clog2(DEPTH)    byte-address width of pc; ROM word address = pc[ADDRESS_WIDTH-1:2]
//   DATA_WIDTH     32               instruction width, equals ROM q width
//   RESET_PC       0                byte address fetched first after reset; bits [1:0] must be 0
// PORTS
//   clk             in   1                       single clock, all logic on posedge
//   rst_n           in   1                       synchronous, active-low reset
//   rom_addr        out  ADDRESS_WIDTH-2         word address to ROM, bits [ADDRESS_WIDTH-1:2] of fetch pc
//   rom_q           in   DATA_WIDTH              ROM data; equals word at rom_addr of the previous cycle
//   redirect_valid  in   1                       load redirect_pc, flush pending fetches
//   redirect_pc     in   ADDRESS_WIDTH           new byte PC; bits [1:0] ignored (forced 0)
//   out_valid       out  1                       out_instr/out_pc hold a fetched instruction
//   out_ready       in   1                       consumer accepts when out_valid & out_ready
//   out_instr       out  DATA_WIDTH              instruction word
//   out_pc          out  ADDRESS_WIDTH           byte address of out_instr
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - pc<=RESET_PC; FIFO count<=0; inflight<=0
//     - out_valid=0, out_instr=0, out_pc=0
//     - rom_addr=RESET_PC[ADDRESS_WIDTH-1:2] from the first cycle after reset
//     - reset mid-stream discards all buffered and in-flight words
//   Addressing:
//     - rom_addr = pc[ADDRESS_WIDTH-1:2], a direct register output with no combinational path
//     - the ROM reads every cycle; the block decides which returned words to keep
//   Issue: issue = (count + inflight - pop) < 2, where pop = out_valid & out_ready
//     - on issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (wraps mod 2^ADDRESS_WIDTH)
//     - otherwise: inflight<=0, pc holds
//   Capture: if inflight, push {inflight_pc, rom_q} into the FIFO
//     - FIFO can never overflow by construction; an overflow is an assertion failure
//   Output: out_* always reflect the FIFO head; out_valid = (count != 0)
//     - same-cycle push and pop keeps count unchanged
//     - out_instr/out_pc must stay stable while out_valid & !out_ready
//   Latency:
//     - first out_valid 2 cycles after reset release: addr at cycle 0, q at 1, out_valid at 2
//     - redirect also costs 2 cycles: asserted at N -> rom_addr=new at N+1 -> out_valid at N+3, out_pc=redirect_pc
//     - steady state with out_ready=1: one instruction per cycle, consecutive pcs
//   Back-pressure:
//     - out_ready low: FIFO fills to 2, issue stops, pc and rom_addr hold
//     - out_ready back high: throughput resumes on the next cycle with no bubble
//   Redirect (redirect_valid=1 at posedge):
//     - pc<=redirect_pc & ~3; count<=0; inflight<=0; the ROM word returned next cycle is dropped
//     - a transfer completing in the redirect cycle (out_valid & out_ready) counts as accepted
//     - all other buffered words are discarded
//     - redirect takes priority over issue and capture
//     - back-to-back redirects: only the last takes effect
//     - rst_n=0 takes priority over redirect
// TESTING
//   1 Reset, out_ready=1, ROM word i = 0x1000_0000+i, RESET_PC=0
//     -> out_valid rises 2 cycles after reset release
//     -> then out_pc=0,4,8,...; out_instr=0x1000_0000,0x1000_0001,... one per cycle
//   2 out_ready=0 for 5 cycles mid-stream
//     -> FIFO holds 2 words; out_pc/out_instr stable; rom_addr frozen
//     -> on release, pcs continue with no gap or duplicate
//   3 redirect_valid with redirect_pc=0x103 while 2 words buffered
//     -> next valid out_pc=0x100, out_instr=0x1000_0040
//     -> no stale pc appears; out_valid low for exactly 2 cycles
//   4 redirect in the same cycle as an accepted handshake at out_pc=0x20
//     -> 0x20 is consumed; the next out_pc is the redirect target
//   5 pc at (2^ADDRESS_WIDTH)-4 with out_ready=1
//     -> out_pc wraps to 0 after it, out_instr=0x1000_0000
//   6 rst_n low for 1 cycle mid-stream with FIFO full
//     -> out_valid=0 next cycle; fetch restarts at RESET_PC
//     -> random out_ready toggling afterwards preserves order (scoreboard)

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: ROM read port plus the valid/ready instruction stream to decode.
// The master modport is the fetch unit; slave is the ROM/decode/branch-unit side.
interface instr_fetch_if #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-3:0] rom_addr;
  logic [DATA_WIDTH-1:0]    rom_q;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc,
    input  rom_q, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc,
    output rom_q, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: owns the fetch pc, reads a 1-cycle-latency ROM every cycle,
// and streams {pc, instr} to decode through a 2-entry skid FIFO with redirect/flush.
module instr_fetch #(
  parameter int unsigned              DEPTH         = 16384,
  parameter int unsigned              ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [AW-1:0] PC_ALIGN_MASK = ~AW'(3);
  localparam logic [AW-1:0] PC_STEP       = AW'(4);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_entry_t;

  // fetch pointer and the single outstanding ROM read
  logic [AW-1:0] pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc;

  // shift-style FIFO: head is always slot 0 so outputs come straight from flops
  fetch_entry_t head;
  fetch_entry_t tail;
  logic         head_vld;
  logic         tail_vld;

  fetch_entry_t head_nxt;
  fetch_entry_t tail_nxt;
  logic         head_vld_nxt;
  logic         tail_vld_nxt;
  fetch_entry_t captured;
  logic         pop;
  logic         push;
  logic         issue;
  logic         overflow;
  logic [1:0]   count;
  logic [2:0]   occupancy;

  assign pop       = head_vld & bus.out_ready;
  assign push      = inflight;
  assign count     = {1'b0, head_vld} + {1'b0, tail_vld};
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue     = (occupancy < 3'd2);
  assign captured  = '{pc: inflight_pc, instr: bus.rom_q};

  // FIFO next-state: retire the head first, then land the returning word in the first free slot
  always_comb begin
    head_nxt     = head;
    tail_nxt     = tail;
    head_vld_nxt = head_vld;
    tail_vld_nxt = tail_vld;
    overflow     = 1'b0;
    if (pop) begin
      head_nxt     = tail;
      head_vld_nxt = tail_vld;
      tail_vld_nxt = 1'b0;
    end
    if (push) begin
      if (!head_vld_nxt) begin
        head_nxt     = captured;
        head_vld_nxt = 1'b1;
      end else if (!tail_vld_nxt) begin
        tail_nxt     = captured;
        tail_vld_nxt = 1'b1;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  // reset beats redirect, redirect beats issue/capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC & PC_ALIGN_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      head_vld    <= 1'b0;
      tail_vld    <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc & PC_ALIGN_MASK;
      inflight <= 1'b0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
      head     <= head_nxt;
      tail     <= tail_nxt;
      head_vld <= head_vld_nxt;
      tail_vld <= tail_vld_nxt;
    end
  end

  // the issue rule keeps buffered + in-flight words at most 2, so a push never finds both slots busy
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(overflow && !bus.redirect_valid));

  assign bus.rom_addr  = pc[AW-1:2];
  assign bus.out_valid = head_vld;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a per-cycle stream model of the expected
// fetch order, bubble timing after reset/redirect, and ROM address lead.
module tb_instr_fetch;

  localparam int unsigned AW     = 14;
  localparam int unsigned DW     = 32;
  localparam int unsigned WAW    = AW - 2;
  localparam int unsigned NWORDS = 1 << WAW;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch #(
    .DEPTH(16384), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] rom [NWORDS];

  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] pc);
    return 32'h1000_0000 + DW'(pc >> 2);
  endfunction

  // Stream model: after any reset/redirect the output is empty for two cycles, then valid forever;
  // the head is always the next pc in program order and the ROM address leads it by up to 2 words.
  logic [AW-1:0] exp_pc = '0;
  int            since  = 0;
  bit            started = 1'b0;

  always @(negedge clk) begin
    int adv;
    if (started) begin
      if (since <= 2) begin
        chk("valid_gap", 64'(bus.out_valid), 64'(0));
      end else begin
        chk("valid_on", 64'(bus.out_valid), 64'(1));
        if (bus.out_valid === 1'b1) begin
          chk("out_pc", 64'(bus.out_pc), 64'(exp_pc));
          chk("out_instr", 64'(bus.out_instr), 64'(word_of(exp_pc)));
        end
      end
      adv = (since >= 3) ? 2 : since - 1;
      chk("rom_addr", 64'(bus.rom_addr), 64'(WAW'((exp_pc >> 2) + AW'(adv))));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) exp_pc = exp_pc + AW'(4);
    end
    if (rst_n === 1'b0) begin
      started = 1'b1;
      exp_pc  = RESET_PC;
      since   = 1;
    end else if (started) begin
      if (bus.redirect_valid === 1'b1) begin
        exp_pc = bus.redirect_pc & ~AW'(3);
        since  = 1;
      end else if (since < 3) begin
        since++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) rom[i] = 32'h1000_0000 + DW'(i);
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step(2);
    rst_n = 1'b1;

    // reset release and first instructions
    chk("t1_rom_addr_c0", 64'(bus.rom_addr), 64'(0));
    chk("t1_valid_c0", 64'(bus.out_valid), 64'(0));
    step(2);
    chk("t1_valid_c2", 64'(bus.out_valid), 64'(1));
    chk("t1_first_pc", 64'(bus.out_pc), 64'(0));
    chk("t1_first_instr", 64'(bus.out_instr), 64'(32'h1000_0000));
    step(1);
    chk("t1_second_pc", 64'(bus.out_pc), 64'(4));
    chk("t1_second_instr", 64'(bus.out_instr), 64'(32'h1000_0001));

    // back-pressure for 5 cycles at pc 0x10
    step(3);
    chk("t2_stall_pc", 64'(bus.out_pc), 64'(14'h10));
    bus.out_ready = 1'b0;
    step(2);
    chk("t2_rom_addr_hold", 64'(bus.rom_addr), 64'(6));
    step(3);
    chk("t2_rom_addr_frozen", 64'(bus.rom_addr), 64'(6));
    chk("t2_pc_stable", 64'(bus.out_pc), 64'(14'h10));
    chk("t2_instr_stable", 64'(bus.out_instr), 64'(32'h1000_0004));
    bus.out_ready = 1'b1;
    step(1);
    chk("t2_resume_pc", 64'(bus.out_pc), 64'(14'h14));
    step(1);
    chk("t2_resume_pc2", 64'(bus.out_pc), 64'(14'h18));

    // redirect to an unaligned target with the FIFO full
    bus.out_ready = 1'b0;
    step(2);
    do_redirect(14'h103);
    bus.out_ready = 1'b1;
    chk("t3_rom_addr_new", 64'(bus.rom_addr), 64'(12'h40));
    chk("t3_valid_n1", 64'(bus.out_valid), 64'(0));
    step(1);
    chk("t3_valid_n2", 64'(bus.out_valid), 64'(0));
    step(1);
    chk("t3_target_pc", 64'(bus.out_pc), 64'(14'h100));
    chk("t3_target_instr", 64'(bus.out_instr), 64'(32'h1000_0040));

    // redirect coinciding with an accepted transfer at 0x20
    do_redirect(14'h20);
    step(2);
    chk("t4_head_pc", 64'(bus.out_pc), 64'(14'h20));
    chk("t4_head_valid", 64'(bus.out_valid), 64'(1));
    do_redirect(14'h200);
    chk("t4_flushed", 64'(bus.out_valid), 64'(0));
    step(2);
    chk("t4_target_pc", 64'(bus.out_pc), 64'(14'h200));
    chk("t4_target_instr", 64'(bus.out_instr), 64'(32'h1000_0080));

    // pc wrap at the top of the address space
    do_redirect(14'h3FF8);
    step(2);
    chk("t5_pc_3ff8", 64'(bus.out_pc), 64'(14'h3FF8));
    step(1);
    chk("t5_pc_3ffc", 64'(bus.out_pc), 64'(14'h3FFC));
    chk("t5_instr_top", 64'(bus.out_instr), 64'(32'h1000_0FFF));
    step(1);
    chk("t5_wrap_pc", 64'(bus.out_pc), 64'(0));
    chk("t5_wrap_instr", 64'(bus.out_instr), 64'(32'h1000_0000));

    // one-cycle reset with FIFO full and a competing redirect
    bus.out_ready = 1'b0;
    step(3);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 14'h300;
    step(1);
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    chk("t6_valid_after_rst", 64'(bus.out_valid), 64'(0));
    chk("t6_rom_addr_restart", 64'(bus.rom_addr), 64'(0));
    bus.out_ready = 1'b1;
    step(2);
    chk("t6_restart_pc", 64'(bus.out_pc), 64'(0));

    // random back-pressure with occasional redirects, order checked by the model
    for (int i = 0; i < 400; i++) begin
      bus.out_ready      = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = AW'($urandom);
      step(1);
    end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
